// File: rtl/key_event_pkg.sv
// Shared types and constants for the keypad event queue.
// An event is {press, code[4:0]}, where code = {column[2:0], row[1:0]}.
package key_event_pkg;

  localparam int KEY_COLS    = 5;
  localparam int KEY_ROWS    = 4;
  localparam int CODE_W      = 5;
  localparam int ROW_W       = $clog2(KEY_ROWS);
  localparam int COL_W       = CODE_W - ROW_W;
  localparam int EV_W        = CODE_W + 1;
  localparam int EV_PRESS    = EV_W - 1;
  localparam int EV_CODE_MSB = CODE_W - 1;
  localparam int EV_CODE_LSB = 0;
  localparam logic [COL_W-1:0] COL_INVALID = 3'h7;

  typedef struct packed {
    logic              press;
    logic [CODE_W-1:0] code;
  } key_event_t;

  typedef enum logic {
    TRK_IDLE = 1'b0,
    TRK_HELD = 1'b1
  } trk_state_t;

  // Columns above the last physical one come from a malformed scan.
  function automatic logic key_code_ok(input logic [CODE_W-1:0] code);
    return code[CODE_W-1:ROW_W] < COL_W'(KEY_COLS);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock show-ahead FIFO; the head entry is visible on dout whenever not empty.
// A push into a full FIFO succeeds only if a pop frees a slot in the same cycle.
module sync_fifo_fwft #(
  parameter  int WIDTH = 6,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Gate the head so an empty FIFO always presents zeros.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// Turns the scanner's ready/keycode level into press/release events and queues them.
// state | meaning
// IDLE  | no key tracked; waiting for a valid key to appear
// HELD  | held_code is down; pending=1 means a slide's press is still owed
module key_event_queue
  import key_event_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_ready,
  input  logic [CODE_W-1:0] key_code,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic              ev_press,
  output logic [CODE_W-1:0] ev_code,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic [AW:0]       level
);

  trk_state_t        state, state_n;
  logic [CODE_W-1:0] held_code, held_code_n;
  logic [CODE_W-1:0] new_code, new_code_n;
  logic              pending, pending_n;
  logic              key_ready_q;
  logic [CODE_W-1:0] key_code_q;
  logic              push;
  key_event_t        push_ev;
  logic [EV_W-1:0]   head;
  logic              fifo_empty;
  logic              fifo_full;
  logic              key_edge;

  // A fresh key is seen on a rise of ready or a change of code while ready stays high.
  assign key_edge = ~key_ready_q | (key_code != key_code_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= TRK_IDLE;
      held_code   <= '0;
      new_code    <= '0;
      pending     <= 1'b0;
      key_ready_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      state       <= state_n;
      held_code   <= held_code_n;
      new_code    <= new_code_n;
      pending     <= pending_n;
      key_ready_q <= key_ready;
      key_code_q  <= key_code;
    end
  end

  always_comb begin
    state_n     = state;
    held_code_n = held_code;
    new_code_n  = new_code;
    pending_n   = pending;
    push        = 1'b0;
    push_ev     = '0;
    case (state)
      TRK_IDLE: begin
        if (key_ready && key_edge && key_code_ok(key_code)) begin
          push        = 1'b1;
          push_ev     = '{press: 1'b1, code: key_code};
          held_code_n = key_code;
          state_n     = TRK_HELD;
        end
      end
      TRK_HELD: begin
        if (!key_ready) begin
          // A slide's release is already queued, so a drop mid-slide adds nothing.
          if (!pending) begin
            push    = 1'b1;
            push_ev = '{press: 1'b0, code: held_code};
          end
          pending_n = 1'b0;
          state_n   = TRK_IDLE;
        end else if (pending) begin
          push        = 1'b1;
          push_ev     = '{press: 1'b1, code: new_code};
          held_code_n = new_code;
          pending_n   = 1'b0;
        end else if (key_code != held_code) begin
          push       = 1'b1;
          push_ev    = '{press: 1'b0, code: held_code};
          new_code_n = key_code;
          pending_n  = 1'b1;
        end
      end
      default: state_n = TRK_IDLE;
    endcase
  end

  sync_fifo_fwft #(
    .WIDTH (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_ev),
    .pop   (ev_ready),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );

  assign ev_valid = ~fifo_empty;
  assign ev_press = head[EV_PRESS];
  assign ev_code  = head[EV_CODE_MSB:EV_CODE_LSB];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (push && fifo_full && !ev_ready) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Sits directly downstream of the keypad scanner and consumes its debounced `ready` level and 5-bit `keycode`.
- Converts that level/code pair into discrete press and release events.
- Buffers events in a small first-word-fall-through (show-ahead) FIFO.
- Presents them to the game/melody logic over a valid/ready handshake, so no key transition is lost while the consumer is busy.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- AW, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock; same clock as the keypad scanner.
- rst_n  in  1  asynchronous, active-low reset.
- key_ready  in  1  debounced "exactly one key held" level from the scanner.
- key_code  in  5  held key: [1:0] row, [4:2] column; valid only while key_ready=1.
- ev_valid  out  1  head-of-FIFO event available.
- ev_ready  in  1  consumer accepts the head event this cycle.
- ev_press  out  1  1 = press event, 0 = release event.
- ev_code  out  5  keycode of the event.
- ovf  out  1  sticky overflow flag: an event was dropped because the FIFO was full.
- ovf_clr  in  1  synchronous clear of ovf.
- level  out  AW+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - FIFO is empty; ev_valid=0, ev_press=0, ev_code=0, ovf=0, level=0.
  - Tracker state is IDLE; held_code=0; pending=0.
- Input registers: key_ready_q and key_code_q sample the inputs every cycle. Detection compares the live inputs against these registered copies.
- Tracker FSM:
  - IDLE:
    - key_ready=1 with key_code[4:2]<=4 → push PRESS(key_code), held_code<=key_code, go to HELD.
    - key_ready=1 with key_code[4:2]>4 → ignored (malformed), stay IDLE.
  - HELD, key_ready falls to 0 → push RELEASE(held_code), go to IDLE.
  - HELD, key_ready=1 but key_code differs from held_code (slide to another key without a debounced gap):
    - Cycle 1: push RELEASE(held_code), set pending=1, latch new_code.
    - Cycle 2: push PRESS(new_code), held_code<=new_code, pending=0.
    - If key_ready drops while pending=1, the pending press is cancelled, state goes to IDLE, and only the release is queued.
- Event latency: a qualifying edge on key_ready sampled at clock edge k is written at edge k; ev_valid is high after edge k when the FIFO was empty. One event is pushed at most per cycle.
- Handshake:
  - Pop occurs when ev_valid & ev_ready.
  - ev_press/ev_code show the head entry combinationally from FIFO storage and hold stable while ev_valid=1 & ev_ready=0.
  - ev_ready while empty has no effect.
- Full: a push while level==DEPTH and no pop in the same cycle is dropped, and ovf<=1. Tracker state still advances, so held_code stays consistent with the keypad.
- Simultaneous push and pop:
  - When full, both succeed and level is unchanged.
  - When empty, no pop happens (ev_valid=0); the push lands and level becomes 1.
- ovf_clr in the same cycle as a new overflow: the set wins and ovf stays 1.
- Pointers are AW bits wide and wrap modulo DEPTH. Occupancy uses an AW+1-bit count; full is level==DEPTH and empty is level==0.
- Mid-operation reset: all queued events are discarded. A key still held after reset release produces a fresh PRESS, because the tracker starts in IDLE.

Decomposition:
- Package key_event_pkg:
  - EV_W=6 and the event layout {press, code[4:0]}.
  - Field indices, KEY_COLS=5, KEY_ROWS=4, COL_INVALID=3'h7.
  - Function key_code_ok(code).
- One sub-module, sync_fifo_fwft (params WIDTH, DEPTH):
  - Ports: push, din, pop, dout, empty, full, level.
  - Same clk and async active-low rst_n.
- The tracker FSM and overflow logic live in key_event_queue.

Test Plan:
1. Press/release: key_ready 0→1 with key_code=5'b01010 for 20 cycles, then 0, with ev_ready=1 → exactly two events: {1,01010} one cycle after the rise, then {0,01010} one cycle after the fall.
2. Slide: hold 5'b00001, then switch to 5'b10010 with key_ready held at 1 → events {0,00001} then {1,10010} on consecutive cycles; later release gives {0,10010}.
3. Backpressure/overflow (DEPTH=8, ev_ready=0): 5 press/release pairs → level=8, ovf=1 after the 9th event, events 9–10 lost; ovf_clr pulse → ovf=0; draining yields the first 8 events in order.
4. Full with simultaneous push and pop: level=8, ev_ready=1 in the same cycle as a new event → level stays 8, ovf stays 0, order preserved.
5. Malformed code: key_ready=1 with key_code[4:2]=3'h7 → no event, state IDLE, level=0.
6. Reset mid-hold: assert rst_n=0 while held with level=3 → outputs go to 0 immediately; after release with the key still down, a single {1,code} event appears.
